// File: rtl/gpio_cfg_serial_loader_if.sv
// Bus bundle between the GPIO configuration loader and its environment:
// start/busy/done handshake, register-file read port and the serial chain.
// With GPIO_CFG_READBACK_EN defined the chain tail input and the readback
// CRC are part of the bundle as well.
interface gpio_cfg_serial_loader_if #(
    parameter int ADDR_W   = 6,
    parameter int CFG_BITS = 13
) ();
    logic                start;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [CFG_BITS-1:0] cfg_data;
    logic                serial_clock;
    logic                serial_data_out;
    logic                serial_load;
`ifdef GPIO_CFG_READBACK_EN
    logic                serial_data_in;
    logic [15:0]         rb_crc;
`endif

`ifdef GPIO_CFG_READBACK_EN
    // loader side
    modport master (
        input  start, cfg_data, serial_data_in,
        output busy, done, cfg_addr, serial_clock, serial_data_out, serial_load, rb_crc
    );
    // environment side (register file, chain, sequencer)
    modport slave (
        output start, cfg_data, serial_data_in,
        input  busy, done, cfg_addr, serial_clock, serial_data_out, serial_load, rb_crc
    );
`else
    // loader side
    modport master (
        input  start, cfg_data,
        output busy, done, cfg_addr, serial_clock, serial_data_out, serial_load
    );
    // environment side (register file, chain, sequencer)
    modport slave (
        output start, cfg_data,
        input  busy, done, cfg_addr, serial_clock, serial_data_out, serial_load
    );
`endif
endinterface

// File: rtl/gpio_cfg_serial_loader.sv
// GPIO pad configuration loader: walks pad indices from N_PADS-1 down to 0,
// shifts each CFG_BITS word MSB first onto the serial configuration chain and
// finishes with a load strobe so the pad control blocks latch the new words.
// Optional feature macro: GPIO_CFG_READBACK_EN (CRC-16-CCITT over the chain
// tail, sampled on each serial_clock rising edge).
//
// State    | Meaning
// IDLE     | waiting for start, serial outputs low
// FETCH    | capture cfg_data for pad cfg_addr into the shift register
// SHIFT_LO | serial_clock low, current bit presented on serial_data_out
// SHIFT_HI | serial_clock high, chain samples the bit
// LOAD_LO  | quiet gap after the last bit, everything low
// LOAD_HI  | serial_load high, chain latches
// DONE     | one-cycle done pulse, busy dropped
module gpio_cfg_serial_loader #(
    parameter int N_PADS   = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 4,
    localparam int ADDR_W  = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
    input  logic                      clock,
    input  logic                      resetb,
    gpio_cfg_serial_loader_if.master  bus
);

    localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

    localparam logic [7:0]        PHASE_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(CFG_BITS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST    = ADDR_W'(N_PADS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LOAD_LO,
        ST_LOAD_HI,
        ST_DONE
    } state_t;

    state_t              state_q,  state_d;
    logic [7:0]          phase_q,  phase_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [CFG_BITS-1:0] shreg_q,  shreg_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                sclk_q,   sclk_d;
    logic                sdo_q,    sdo_d;
    logic                sload_q,  sload_d;
`ifdef GPIO_CFG_READBACK_EN
    logic [15:0]         crc_q,    crc_d;
    logic                crc_fb;
`endif

    logic [CFG_BITS-1:0] cfg_word;
    logic                phase_end;

    assign cfg_word  = bus.cfg_data;
    assign phase_end = (phase_q == 8'd0);

    // Next-state, datapath updates and registered-output decode.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        addr_d   = addr_q;
        sdo_d    = sdo_q;
`ifdef GPIO_CFG_READBACK_EN
        crc_d    = crc_q;
        crc_fb   = crc_q[15] ^ bus.serial_data_in;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d  = ADDR_LAST;
                    state_d = ST_FETCH;
`ifdef GPIO_CFG_READBACK_EN
                    crc_d   = 16'hFFFF;
`endif
                end
            end
            ST_FETCH: begin
                shreg_d  = cfg_word;
                bitcnt_d = BIT_LAST;
                state_d  = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (phase_end) begin
                    state_d = ST_SHIFT_HI;
`ifdef GPIO_CFG_READBACK_EN
                    crc_d   = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
                end
            end
            ST_SHIFT_HI: begin
                if (phase_end) begin
                    if (bitcnt_q != '0) begin
                        shreg_d  = shreg_q << 1;
                        bitcnt_d = bitcnt_q - BIT_W'(1);
                        state_d  = ST_SHIFT_LO;
                    end else if (addr_q != '0) begin
                        addr_d  = addr_q - ADDR_W'(1);
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_LOAD_LO;
                    end
                end
            end
            ST_LOAD_LO: begin
                if (phase_end) begin
                    state_d = ST_LOAD_HI;
                end
            end
            ST_LOAD_HI: begin
                if (phase_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state entry restarts the phase timer; otherwise count down to zero.
        if (state_d != state_q) begin
            phase_d = PHASE_RELOAD;
        end else if (!phase_end) begin
            phase_d = phase_q - 8'd1;
        end

        // Data only moves when a new bit period starts; cleared ahead of the strobe.
        if (state_d == ST_SHIFT_LO && state_q != ST_SHIFT_LO) begin
            sdo_d = shreg_d[CFG_BITS-1];
        end else if (state_d == ST_LOAD_LO || state_d == ST_IDLE) begin
            sdo_d = 1'b0;
        end

        // Outputs are decoded from the next state so the flops track the state exactly.
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d  = (state_d == ST_DONE);
        sclk_d  = (state_d == ST_SHIFT_HI);
        sload_d = (state_d == ST_LOAD_HI);
    end

    // State, datapath and output flops; reset drops the chain outputs at once.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q  <= ST_IDLE;
            phase_q  <= 8'd0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            sdo_q    <= 1'b0;
            sload_q  <= 1'b0;
`ifdef GPIO_CFG_READBACK_EN
            crc_q    <= 16'hFFFF;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sclk_q   <= sclk_d;
            sdo_q    <= sdo_d;
            sload_q  <= sload_d;
`ifdef GPIO_CFG_READBACK_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.cfg_addr        = addr_q;
    assign bus.serial_clock    = sclk_q;
    assign bus.serial_data_out = sdo_q;
    assign bus.serial_load     = sload_q;
`ifdef GPIO_CFG_READBACK_EN
    assign bus.rb_crc          = crc_q;
`endif

endmodule
